// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank and its read-side sweep sequencer.
package reg_bank_pkg;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_TOTAL_REGS = 25;
    localparam int DEF_ADDR_W     = idx_w(32);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT_A,
        EMIT_B,
        DONE
    } state_e;

endpackage

// File: rtl/reg_bank_reader_if.sv
// Valid/ready beat stream carrying one register (data, index, last flag) per transfer.
interface reg_bank_reader_if import reg_bank_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_bank_reader_buffer.sv
// Two-slot capture buffer for one register pair; slots load only on capture,
// so the selected output holds steady while the sink stalls.
module reg_pair_buffer import reg_bank_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_i,
    input  logic             hasB_i,
    input  logic [WIDTH-1:0] rdA_i,
    input  logic [WIDTH-1:0] rdB_i,
    input  logic             selB_i,
    output logic             bValid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] slotA_q;
    logic [WIDTH-1:0] slotB_q;
    logic             aValid_q;
    logic             bValid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotA_q  <= '0;
            slotB_q  <= '0;
            aValid_q <= 1'b0;
            bValid_q <= 1'b0;
        end else if (capture_i) begin
            slotA_q  <= rdA_i;
            slotB_q  <= hasB_i ? rdB_i : '0;
            aValid_q <= 1'b1;
            bValid_q <= hasB_i;
        end
    end

    assign bValid_o = bValid_q;

    always_comb begin
        data_o = '0;
        if (selB_i && bValid_q) begin
            data_o = slotB_q;
        end else if (!selB_i && aValid_q) begin
            data_o = slotA_q;
        end
    end

endmodule

// File: rtl/reg_bank_reader.sv
// Read-side sweep sequencer: fetches register pairs through RA1/RA2 and streams
// each register out as one indexed beat, ending with a one-cycle DONE pulse.
module reg_bank_reader import reg_bank_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TOTAL_REGS = DEF_TOTAL_REGS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   ra1_o,
    output logic [ADDR_W-1:0]   ra2_o,
    input  logic [WIDTH-1:0]    rd1_i,
    input  logic [WIDTH-1:0]    rd2_i,
    reg_bank_reader_if.master   stream
);

    // One extra counter bit keeps base+1..base+3 from wrapping when all 32 registers are swept.
    localparam int            CW       = ADDR_W + 1;
    localparam logic [CW-1:0] NREGS    = CW'(TOTAL_REGS);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL_REGS - 1);

    state_e            state_q;
    logic [CW-1:0]     base_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              last_q;
    logic              selB_q;
    logic [ADDR_W-1:0] ra1_q;
    logic [ADDR_W-1:0] ra2_q;
    logic [ADDR_W-1:0] idx_q;

    logic [CW-1:0]     baseP1_d;
    logic [CW-1:0]     baseP2_d;
    logic [CW-1:0]     baseP3_d;
    logic              hasB_d;
    logic              capture_d;
    logic              xfer_d;
    logic              bValid;
    logic [WIDTH-1:0]  bufData;

    assign baseP1_d  = base_q + CW'(1);
    assign baseP2_d  = base_q + CW'(2);
    assign baseP3_d  = base_q + CW'(3);
    assign hasB_d    = (baseP1_d < NREGS);
    assign capture_d = (state_q == FETCH);
    assign xfer_d    = valid_q & stream.out_ready;

    reg_pair_buffer #(.WIDTH(WIDTH)) u_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture_i(capture_d),
        .hasB_i   (hasB_d),
        .rdA_i    (rd1_i),
        .rdB_i    (rd2_i),
        .selB_i   (selB_q),
        .bValid_o (bValid),
        .data_o   (bufData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            selB_q  <= 1'b0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= FETCH;
                        base_q  <= '0;
                        busy_q  <= 1'b1;
                        ra1_q   <= '0;
                        ra2_q   <= (NREGS > CW'(1)) ? ADDR_W'(1) : '0;
                    end
                end
                FETCH: begin
                    state_q <= EMIT_A;
                    valid_q <= 1'b1;
                    selB_q  <= 1'b0;
                    idx_q   <= base_q[ADDR_W-1:0];
                    last_q  <= (base_q == LAST_IDX);
                end
                EMIT_A: begin
                    if (xfer_d) begin
                        if (bValid) begin
                            state_q <= EMIT_B;
                            selB_q  <= 1'b1;
                            idx_q   <= baseP1_d[ADDR_W-1:0];
                            last_q  <= (baseP1_d == LAST_IDX);
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                            ra1_q   <= '0;
                            ra2_q   <= '0;
                        end
                    end
                end
                EMIT_B: begin
                    if (xfer_d) begin
                        base_q <= baseP2_d;
                        if (baseP2_d < NREGS) begin
                            state_q <= FETCH;
                            valid_q <= 1'b0;
                            ra1_q   <= baseP2_d[ADDR_W-1:0];
                            ra2_q   <= (baseP3_d < NREGS) ? baseP3_d[ADDR_W-1:0] : '0;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                            ra1_q   <= '0;
                            ra2_q   <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign ra1_o            = ra1_q;
    assign ra2_o            = ra2_q;
    assign stream.out_valid = valid_q;
    assign stream.out_data  = bufData;
    assign stream.out_idx   = idx_q;
    assign stream.out_last  = last_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Bench for reg_bank_reader: a behavioural register bank feeds a 25-register and a
// 24-register reader; every sweep is compared with a snapshot of the bank taken at START.
module tb_reg_bank_reader;
    import reg_bank_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NA = 25;
    localparam int NB = 24;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          startA = 1'b0;
    logic          startB = 1'b0;
    logic          busyA, doneA, busyB, doneB;
    logic [AW-1:0] ra1A, ra2A, ra1B, ra2B;
    logic [W-1:0]  rd1A, rd2A, rd1B, rd2B;
    logic [W-1:0]  bank [32];

    int checks = 0;
    int errors = 0;

    int           expIdx[$];
    logic [W-1:0] expData[$];
    bit           expLast[$];
    int           gotIdx[$];
    logic [W-1:0] gotData[$];
    bit           gotLast[$];
    int           doneCount, doneCycle, stallErrs, busyErrs;
    bit           timedOut;

    reg_bank_reader_if #(.WIDTH(W), .ADDR_W(AW)) busA ();
    reg_bank_reader_if #(.WIDTH(W), .ADDR_W(AW)) busB ();

    assign rd1A = bank[ra1A];
    assign rd2A = bank[ra2A];
    assign rd1B = bank[ra1B];
    assign rd2B = bank[ra2B];

    reg_bank_reader #(.WIDTH(W), .TOTAL_REGS(NA), .ADDR_W(AW)) dutA (
        .clk(clk), .rst_n(rst_n), .start_i(startA), .busy_o(busyA), .done_o(doneA),
        .ra1_o(ra1A), .ra2_o(ra2A), .rd1_i(rd1A), .rd2_i(rd2A), .stream(busA)
    );

    reg_bank_reader #(.WIDTH(W), .TOTAL_REGS(NB), .ADDR_W(AW)) dutB (
        .clk(clk), .rst_n(rst_n), .start_i(startB), .busy_o(busyB), .done_o(doneB),
        .ra1_o(ra1B), .ra2_o(ra2B), .rd1_i(rd1B), .rd2_i(rd2B), .stream(busB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep on the 25-register reader and records every transferred beat.
    // mode 0: ready always high, 1: alternating, 2: random.
    task automatic sweepA(input int mode, input int restartAt, input int writeIdx,
                          input logic [W-1:0] writeVal);
        bit           stalled  = 1'b0;
        bit           wrote    = 1'b0;
        int           prevIdx  = 0;
        logic [W-1:0] prevData = '0;
        bit           prevLast = 1'b0;
        int           cyc      = 0;
        expIdx.delete(); expData.delete(); expLast.delete();
        gotIdx.delete(); gotData.delete(); gotLast.delete();
        for (int i = 0; i < NA; i++) begin
            expIdx.push_back(i);
            expData.push_back(bank[i]);
            expLast.push_back(i == NA - 1);
        end
        doneCount = 0; doneCycle = -1; stallErrs = 0; busyErrs = 0;
        busA.out_ready = 1'b1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        while (cyc < 400 && !(doneCount > 0 && cyc >= doneCycle + 4)) begin
            case (mode)
                0:       busA.out_ready = 1'b1;
                1:       busA.out_ready = ((cyc % 2) == 1);
                default: busA.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (writeIdx >= 0 && !wrote && busA.out_valid === 1'b1 && int'(busA.out_idx) == writeIdx) begin
                bank[writeIdx] = writeVal;
                wrote = 1'b1;
            end
            if (stalled && (busA.out_valid !== 1'b1 || int'(busA.out_idx) != prevIdx ||
                            busA.out_data !== prevData || busA.out_last !== prevLast))
                stallErrs++;
            if (doneCount == 0 && busyA !== 1'b1) busyErrs++;
            startA = (restartAt >= 0 && busA.out_valid === 1'b1 && int'(busA.out_idx) == restartAt);
            if (busA.out_valid === 1'b1 && busA.out_ready === 1'b1) begin
                gotIdx.push_back(int'(busA.out_idx));
                gotData.push_back(busA.out_data);
                gotLast.push_back(busA.out_last);
            end
            stalled  = (busA.out_valid === 1'b1) && (busA.out_ready !== 1'b1);
            prevIdx  = int'(busA.out_idx);
            prevData = busA.out_data;
            prevLast = busA.out_last;
            tick();
            cyc++;
            if (doneA === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
                if (busyA !== 1'b0) busyErrs++;
            end
        end
        startA = 1'b0;
        timedOut = (doneCount == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busyA, doneA, ra1A, ra2A, busA.out_valid, busA.out_data, busA.out_idx, busA.out_last} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_A: got %h required 0",
                     {busyA, doneA, ra1A, ra2A, busA.out_valid, busA.out_data, busA.out_idx, busA.out_last});
        end
        checks++;
        if ({busyB, doneB, ra1B, ra2B, busB.out_valid, busB.out_data, busB.out_idx, busB.out_last} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_B: got %h required 0",
                     {busyB, doneB, ra1B, ra2B, busB.out_valid, busB.out_data, busB.out_idx, busB.out_last});
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busyA, doneA, busA.out_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_after_release: got %b required 000", {busyA, doneA, busA.out_valid});
        end
    endtask

    task automatic test_full_sweep();
        sweepA(0, -1, -1, '0);
        checks++;
        if (gotIdx.size() != NA) begin
            errors++;
            $display("[TB] FAIL full_beats: got %0d required %0d", gotIdx.size(), NA);
        end
        for (int i = 0; i < gotIdx.size() && i < NA; i++) begin
            checks++;
            if (gotIdx[i] != expIdx[i] || gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL full_beat%0d: got idx %0d data %0d last %0b required idx %0d data %0d last %0b",
                         i, gotIdx[i], gotData[i], gotLast[i], expIdx[i], expData[i], expLast[i]);
            end
        end
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL full_done_count: got %0d required 1", doneCount);
        end
        checks++;
        if (doneCycle != (NA + 1) / 2 + NA) begin
            errors++;
            $display("[TB] FAIL full_done_latency: got %0d required %0d", doneCycle, (NA + 1) / 2 + NA);
        end
        checks++;
        if (busyErrs != 0) begin
            errors++;
            $display("[TB] FAIL full_busy: got %0d bad cycles required 0", busyErrs);
        end
    endtask

    task automatic test_backpressure();
        sweepA(1, -1, -1, '0);
        checks++;
        if (gotIdx.size() != NA || timedOut) begin
            errors++;
            $display("[TB] FAIL bp_beats: got %0d required %0d", gotIdx.size(), NA);
        end
        for (int i = 0; i < gotIdx.size() && i < NA; i++) begin
            checks++;
            if (gotIdx[i] != expIdx[i] || gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL bp_beat%0d: got idx %0d data %0d required idx %0d data %0d",
                         i, gotIdx[i], gotData[i], expIdx[i], expData[i]);
            end
        end
        checks++;
        if (stallErrs != 0) begin
            errors++;
            $display("[TB] FAIL bp_stall_stable: got %0d unstable cycles required 0", stallErrs);
        end
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL bp_done_count: got %0d required 1", doneCount);
        end
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < NA; i++) bank[i] = $urandom();
        sweepA(2, -1, -1, '0);
        checks++;
        if (gotIdx.size() != NA || timedOut) begin
            errors++;
            $display("[TB] FAIL rnd_beats: got %0d required %0d", gotIdx.size(), NA);
        end
        for (int i = 0; i < gotIdx.size() && i < NA; i++) begin
            checks++;
            if (gotIdx[i] != expIdx[i] || gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
                errors++;
                $display("[TB] FAIL rnd_beat%0d: got idx %0d data %h required idx %0d data %h",
                         i, gotIdx[i], gotData[i], expIdx[i], expData[i]);
            end
        end
        checks++;
        if (stallErrs != 0 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL rnd_stall_done: got %0d unstable, %0d dones required 0, 1", stallErrs, doneCount);
        end
        for (int i = 0; i < 32; i++) bank[i] = W'(100 + i);
    endtask

    task automatic test_start_ignored();
        sweepA(0, 7, -1, '0);
        checks++;
        if (gotIdx.size() != NA) begin
            errors++;
            $display("[TB] FAIL restart_beats: got %0d required %0d", gotIdx.size(), NA);
        end
        for (int i = 0; i < gotIdx.size() && i < NA; i++) begin
            checks++;
            if (gotIdx[i] != expIdx[i] || gotData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL restart_beat%0d: got idx %0d data %0d required idx %0d data %0d",
                         i, gotIdx[i], gotData[i], expIdx[i], expData[i]);
            end
        end
        checks++;
        if (doneCount != 1 || doneCycle != (NA + 1) / 2 + NA) begin
            errors++;
            $display("[TB] FAIL restart_done: got %0d dones at cycle %0d required 1 at %0d",
                     doneCount, doneCycle, (NA + 1) / 2 + NA);
        end
    endtask

    task automatic test_reset_abort();
        int cyc   = 0;
        int dones = 0;
        busA.out_ready = 1'b1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        while (cyc < 200 && !(busA.out_valid === 1'b1 && int'(busA.out_idx) == 10)) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("[TB] FAIL abort_reach_idx10: got timeout after %0d cycles required idx 10", cyc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busyA, doneA, ra1A, ra2A, busA.out_valid, busA.out_data, busA.out_idx, busA.out_last} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %h required 0",
                     {busyA, doneA, ra1A, ra2A, busA.out_valid, busA.out_data, busA.out_idx, busA.out_last});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (doneA === 1'b1) dones++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (doneA === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d pulses required 0", dones);
        end
        sweepA(0, -1, -1, '0);
        checks++;
        if (gotIdx.size() == 0 || gotIdx[0] != 0 || gotData[0] !== W'(100)) begin
            errors++;
            $display("[TB] FAIL abort_restart_first: got %0d beats, first idx %0d data %0d required idx 0 data 100",
                     gotIdx.size(), (gotIdx.size() > 0) ? gotIdx[0] : -1, (gotData.size() > 0) ? gotData[0] : '0);
        end
        checks++;
        if (gotIdx.size() != NA || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL abort_restart_sweep: got %0d beats %0d dones required %0d beats 1 done",
                     gotIdx.size(), doneCount, NA);
        end
    endtask

    task automatic test_regs24();
        int cyc = 0, beats = 0, badBeats = 0, maxRa2 = 0, lastIdx = -1, lastCount = 0, doneAt = -1;
        busB.out_ready = 1'b1;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        while (cyc < 200 && doneAt < 0) begin
            if (int'(ra2B) > maxRa2) maxRa2 = int'(ra2B);
            if (busB.out_valid === 1'b1) begin
                if (beats >= NB || int'(busB.out_idx) != beats || busB.out_data !== W'(100 + beats) ||
                    busB.out_last !== (beats == NB - 1))
                    badBeats++;
                if (busB.out_last === 1'b1) begin
                    lastIdx = int'(busB.out_idx);
                    lastCount++;
                end
                beats++;
            end
            tick();
            cyc++;
            if (doneB === 1'b1) doneAt = cyc;
        end
        checks++;
        if (beats != NB || badBeats != 0) begin
            errors++;
            $display("[TB] FAIL r24_beats: got %0d beats %0d bad required %0d beats 0 bad", beats, badBeats, NB);
        end
        checks++;
        if (lastIdx != NB - 1 || lastCount != 1) begin
            errors++;
            $display("[TB] FAIL r24_last: got idx %0d x%0d required idx %0d x1", lastIdx, lastCount, NB - 1);
        end
        checks++;
        if (maxRa2 != NB - 1) begin
            errors++;
            $display("[TB] FAIL r24_ra2_max: got %0d required %0d", maxRa2, NB - 1);
        end
        checks++;
        if (doneAt != NB / 2 + NB) begin
            errors++;
            $display("[TB] FAIL r24_done_latency: got %0d required %0d", doneAt, NB / 2 + NB);
        end
    endtask

    task automatic test_write_during_emit();
        sweepA(0, -1, 4, W'(999));
        checks++;
        if (gotData.size() < 6 || gotData[4] !== W'(104) || gotData[5] !== W'(105)) begin
            errors++;
            $display("[TB] FAIL wr_same_sweep: got %0d beats, idx4 %0d idx5 %0d required 104 105",
                     gotData.size(), (gotData.size() > 4) ? gotData[4] : '0, (gotData.size() > 5) ? gotData[5] : '0);
        end
        checks++;
        if (gotIdx.size() != NA || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL wr_sweep_complete: got %0d beats %0d dones required %0d beats 1 done",
                     gotIdx.size(), doneCount, NA);
        end
        sweepA(0, -1, -1, '0);
        checks++;
        if (gotData.size() < 5 || gotData[4] !== W'(999)) begin
            errors++;
            $display("[TB] FAIL wr_next_sweep: got idx4 %0d required 999", (gotData.size() > 4) ? gotData[4] : '0);
        end
        bank[4] = W'(104);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = W'(100 + i);
        busA.out_ready = 1'b0;
        busB.out_ready = 1'b0;
        $display("[TB] starting reg_bank_reader sweeps");
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_reset_abort();
        test_regs24();
        test_write_during_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
